// File: rtl/ase_hssi_rx_pkt_fifo.sv
// Store-and-forward RX packet FIFO between the HSSI emulator and the AFU.
// Overflowing packets are dropped whole; committed packets leave through a registered AXI-S stage.
module ase_hssi_rx_pkt_fifo #(
  parameter int TDATA_WIDTH = 64,
  parameter int TUSER_WIDTH = 8,
  parameter int TKEEP_WIDTH = TDATA_WIDTH/8,
  parameter int DEPTH       = 512
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_tvalid,
  input  logic                     in_tlast,
  input  logic [TDATA_WIDTH-1:0]   in_tdata,
  input  logic [TUSER_WIDTH-1:0]   in_tuser,
  input  logic [TKEEP_WIDTH-1:0]   in_tkeep,
  output logic                     out_tvalid,
  output logic                     out_tlast,
  input  logic                     out_tready,
  output logic [TDATA_WIDTH-1:0]   out_tdata,
  output logic [TUSER_WIDTH-1:0]   out_tuser,
  output logic [TKEEP_WIDTH-1:0]   out_tkeep,
  output logic [$clog2(DEPTH):0]   fill_level,
  output logic [31:0]              pkt_cnt,
  output logic [31:0]              drop_cnt,
  output logic                     drop_pulse
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int BW = TDATA_WIDTH + TUSER_WIDTH + TKEEP_WIDTH + 1;

  typedef enum logic {ACCEPT, DROP} wr_state_t;

  logic [BW-1:0]    r_mem [DEPTH];
  wr_state_t        r_state;
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_wr_commit;
  logic [PW-1:0]    r_commit_vis;
  logic [PW-1:0]    r_rd_ptr;
  logic [31:0]      r_pkt_cnt;
  logic [31:0]      r_drop_cnt;
  logic             r_drop_pulse;
  logic             r_out_valid;
  logic             r_out_last;
  logic [TDATA_WIDTH-1:0] r_out_data;
  logic [TUSER_WIDTH-1:0] r_out_user;
  logic [TKEEP_WIDTH-1:0] r_out_keep;

  logic [PW-1:0]    w_occ;
  logic             w_full;
  logic             w_wr_en;
  logic             w_load;

  assign w_occ   = r_wr_ptr - r_rd_ptr;
  assign w_full  = (w_occ == PW'(DEPTH));
  assign w_wr_en = in_tvalid && (r_state == ACCEPT) && !w_full;
  // Reads follow a one-cycle-delayed copy of the commit pointer; this gives the
  // tlast-to-first-beat latency of two edges without a bubble in steady state.
  assign w_load  = (r_rd_ptr != r_commit_vis) && (!r_out_valid || out_tready);

  always_ff @(posedge clk) begin
    if (rst_n && w_wr_en)
      r_mem[r_wr_ptr[AW-1:0]] <= {in_tlast, in_tkeep, in_tuser, in_tdata};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ACCEPT;
      r_wr_ptr     <= '0;
      r_wr_commit  <= '0;
      r_commit_vis <= '0;
      r_pkt_cnt    <= '0;
      r_drop_cnt   <= '0;
      r_drop_pulse <= 1'b0;
    end else begin
      r_drop_pulse <= 1'b0;
      r_commit_vis <= r_wr_commit;
      case (r_state)
        ACCEPT: begin
          if (in_tvalid) begin
            if (!w_full) begin
              r_wr_ptr <= r_wr_ptr + PW'(1);
              if (in_tlast) begin
                r_wr_commit <= r_wr_ptr + PW'(1);
                if (r_pkt_cnt != '1) r_pkt_cnt <= r_pkt_cnt + 32'd1;
              end
            end else begin
              r_wr_ptr     <= r_wr_commit;
              r_drop_pulse <= 1'b1;
              if (r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + 32'd1;
              if (!in_tlast) r_state <= DROP;
            end
          end
        end
        DROP: begin
          if (in_tvalid && in_tlast) r_state <= ACCEPT;
        end
        default: r_state <= ACCEPT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rd_ptr    <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_data  <= '0;
      r_out_user  <= '0;
      r_out_keep  <= '0;
    end else if (w_load) begin
      r_rd_ptr    <= r_rd_ptr + PW'(1);
      r_out_valid <= 1'b1;
      {r_out_last, r_out_keep, r_out_user, r_out_data} <= r_mem[r_rd_ptr[AW-1:0]];
    end else if (out_tready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_tvalid = r_out_valid;
  assign out_tlast  = r_out_last;
  assign out_tdata  = r_out_data;
  assign out_tuser  = r_out_user;
  assign out_tkeep  = r_out_keep;
  assign fill_level = w_occ;
  assign pkt_cnt    = r_pkt_cnt;
  assign drop_cnt   = r_drop_cnt;
  assign drop_pulse = r_drop_pulse;

endmodule

// File: tb/tb_ase_hssi_rx_pkt_fifo.sv
// Bench for ase_hssi_rx_pkt_fifo: queue-based packet model checked every cycle,
// directed scenarios with literal expectations, and a randomized throttle run.
module tb_ase_hssi_rx_pkt_fifo;

  localparam int DW = 32;
  localparam int UW = 4;
  localparam int KW = 4;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_tvalid = 1'b0;
  logic          in_tlast = 1'b0;
  logic [DW-1:0] in_tdata = '0;
  logic [UW-1:0] in_tuser = '0;
  logic [KW-1:0] in_tkeep = '0;
  logic          out_tvalid;
  logic          out_tlast;
  logic          out_tready = 1'b0;
  logic [DW-1:0] out_tdata;
  logic [UW-1:0] out_tuser;
  logic [KW-1:0] out_tkeep;
  logic [$clog2(DEPTH):0] fill_level;
  logic [31:0]   pkt_cnt;
  logic [31:0]   drop_cnt;
  logic          drop_pulse;

  ase_hssi_rx_pkt_fifo #(
    .TDATA_WIDTH(DW), .TUSER_WIDTH(UW), .TKEEP_WIDTH(KW), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_tvalid(in_tvalid), .in_tlast(in_tlast),
    .in_tdata(in_tdata), .in_tuser(in_tuser), .in_tkeep(in_tkeep),
    .out_tvalid(out_tvalid), .out_tlast(out_tlast), .out_tready(out_tready),
    .out_tdata(out_tdata), .out_tuser(out_tuser), .out_tkeep(out_tkeep),
    .fill_level(fill_level), .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt),
    .drop_pulse(drop_pulse)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic          l;
    logic [KW-1:0] k;
    logic [UW-1:0] u;
    logic [DW-1:0] d;
  } beat_t;

  // Model: storage is a queue of beats (committed ones first, the open packet at the tail).
  // A committed packet becomes readable one edge after its tlast is written.
  beat_t m_store[$];
  int    m_uncmt = 0, m_vis = 0, m_new = 0;
  bit    m_drop = 0, m_pulse = 0, m_ov = 0, m_live = 0;
  beat_t m_ob;
  int    m_pkt = 0, m_dropc = 0;

  int cyc = 0, tl_cyc = -1, first_v = -1, last_v = -1;
  int n_val = 0, n_hs = 0, n_last = 0, n_pulse = 0;
  bit rand_rdy = 0;

  always @(posedge clk) begin
    int occ, newc;
    bit load, pulse;
    beat_t b;
    cyc++;
    if (!rst_n) begin
      m_store.delete();
      m_uncmt = 0; m_vis = 0; m_new = 0;
      m_drop = 0; m_pulse = 0; m_ov = 0; m_ob = '0;
      m_pkt = 0; m_dropc = 0; m_live = 1;
    end else begin
      if (in_tvalid && in_tlast && tl_cyc < 0) tl_cyc = cyc;
      occ = m_store.size();
      load = (m_vis > 0) && (!m_ov || out_tready);
      newc = 0; pulse = 0;
      if (load) begin
        m_ob = m_store.pop_front();
        m_ov = 1;
      end else if (out_tready) begin
        m_ov = 0;
      end
      if (!m_drop && in_tvalid) begin
        if (occ < DEPTH) begin
          b = '{l: in_tlast, k: in_tkeep, u: in_tuser, d: in_tdata};
          m_store.push_back(b);
          m_uncmt++;
          if (in_tlast) begin
            newc = m_uncmt; m_uncmt = 0; m_pkt++;
          end
        end else begin
          repeat (m_uncmt) void'(m_store.pop_back());
          m_uncmt = 0; pulse = 1; m_dropc++;
          if (!in_tlast) m_drop = 1;
        end
      end else if (m_drop && in_tvalid && in_tlast) begin
        m_drop = 0;
      end
      m_vis = m_vis - (load ? 1 : 0) + m_new;
      m_new = newc;
      m_pulse = pulse;
    end
  end

  always @(negedge clk) begin
    if (out_tvalid === 1'b1) begin
      if (first_v < 0) first_v = cyc;
      last_v = cyc;
      n_val++;
      if (out_tready) begin
        n_hs++;
        if (out_tlast) n_last++;
      end
    end
    if (drop_pulse === 1'b1) n_pulse++;
    if (m_live) begin
      chk("out_tvalid", 64'(out_tvalid), 64'(m_ov));
      if (m_ov) begin
        chk("out_tdata", 64'(out_tdata), 64'(m_ob.d));
        chk("out_tuser", 64'(out_tuser), 64'(m_ob.u));
        chk("out_tkeep", 64'(out_tkeep), 64'(m_ob.k));
        chk("out_tlast", 64'(out_tlast), 64'(m_ob.l));
      end
      chk("fill_level", 64'(fill_level), 64'(m_store.size()));
      chk("pkt_cnt", 64'(pkt_cnt), 64'(m_pkt));
      chk("drop_cnt", 64'(drop_cnt), 64'(m_dropc));
      chk("drop_pulse", 64'(drop_pulse), 64'(m_pulse));
    end
  end

  always @(posedge clk) begin
    if (rand_rdy) begin
      #1;
      out_tready = 1'($urandom_range(0, 1));
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_pkt(input int len);
    for (int i = 0; i < len; i++) begin
      in_tvalid = 1'b1;
      in_tdata  = DW'($urandom);
      in_tuser  = UW'($urandom);
      in_tkeep  = KW'($urandom);
      in_tlast  = (i == len - 1);
      @(posedge clk); #1;
    end
    in_tvalid = 1'b0;
    in_tlast  = 1'b0;
  endtask

  task automatic do_reset();
    in_tvalid = 1'b0; in_tlast = 1'b0;
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
  endtask

  task automatic clr_stats();
    tl_cyc = -1; first_v = -1; last_v = -1;
    n_val = 0; n_hs = 0; n_last = 0; n_pulse = 0;
  endtask

  initial begin
    int sent;
    // Reset values
    do_reset();
    chk("rst_out_tvalid", 64'(out_tvalid), 64'd0);
    chk("rst_out_tdata", 64'(out_tdata), 64'd0);
    chk("rst_fill", 64'(fill_level), 64'd0);
    chk("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
    chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);

    // Single 4-beat packet, ready held high
    out_tready = 1'b1;
    clr_stats();
    send_pkt(4);
    idle(8);
    chk("lat_tlast_to_valid", 64'(first_v - tl_cyc), 64'd2);
    chk("p4_beats", 64'(n_hs), 64'd4);
    chk("p4_lasts", 64'(n_last), 64'd1);
    chk("p4_pkt_cnt", 64'(pkt_cnt), 64'd1);

    // Exactly-full packet then overflow packet with output stalled
    out_tready = 1'b0;
    do_reset();
    clr_stats();
    send_pkt(8);
    send_pkt(3);
    idle(4);
    chk("full_drop_cnt", 64'(drop_cnt), 64'd1);
    chk("full_pulses", 64'(n_pulse), 64'd1);
    chk("full_pkt_cnt", 64'(pkt_cnt), 64'd1);
    chk("full_held_beats", 64'(fill_level) + 64'(out_tvalid), 64'd8);
    out_tready = 1'b1;
    idle(14);
    chk("full_beats_out", 64'(n_hs), 64'd8);

    // Oversized packet is dropped at beat 9
    out_tready = 1'b0;
    do_reset();
    clr_stats();
    send_pkt(10);
    idle(5);
    chk("big_fill", 64'(fill_level), 64'd0);
    chk("big_drop_cnt", 64'(drop_cnt), 64'd1);
    chk("big_pkt_cnt", 64'(pkt_cnt), 64'd0);
    chk("big_valid_cycles", 64'(n_val), 64'd0);

    // Back-to-back single-beat packets across several pointer wraps
    do_reset();
    out_tready = 1'b1;
    clr_stats();
    for (int i = 0; i < 3 * DEPTH; i++) send_pkt(1);
    idle(6);
    chk("b2b_beats", 64'(n_hs), 64'(3 * DEPTH));
    chk("b2b_span", 64'(last_v - first_v + 1), 64'(3 * DEPTH));
    chk("b2b_drop_cnt", 64'(drop_cnt), 64'd0);
    chk("b2b_pkt_cnt", 64'(pkt_cnt), 64'(3 * DEPTH));

    // Reset in the middle of a packet with a committed packet pending
    do_reset();
    out_tready = 1'b0;
    send_pkt(3);
    in_tvalid = 1'b1; in_tlast = 1'b0; in_tdata = DW'($urandom);
    @(posedge clk); #1;
    in_tdata = DW'($urandom);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_valid", 64'(out_tvalid), 64'd0);
    chk("mid_rst_data", 64'(out_tdata), 64'd0);
    chk("mid_rst_last", 64'(out_tlast), 64'd0);
    chk("mid_rst_fill", 64'(fill_level), 64'd0);
    chk("mid_rst_pkt", 64'(pkt_cnt), 64'd0);
    rst_n = 1'b1;
    in_tvalid = 1'b0;
    out_tready = 1'b1;
    clr_stats();
    send_pkt(3);
    idle(6);
    chk("post_rst_beats", 64'(n_hs), 64'd3);
    chk("post_rst_pkt", 64'(pkt_cnt), 64'd1);

    // Random lengths with random output throttle
    do_reset();
    rand_rdy = 1'b1;
    sent = 0;
    for (int p = 0; p < 60; p++) begin
      send_pkt($urandom_range(1, DEPTH / 2));
      sent++;
      idle($urandom_range(0, 2));
    end
    rand_rdy = 1'b0;
    @(posedge clk); #2;
    out_tready = 1'b1;
    idle(3 * DEPTH);
    chk("rand_pkt_plus_drop", 64'(pkt_cnt) + 64'(drop_cnt), 64'(sent));
    chk("rand_drained", 64'(out_tvalid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
